axi4lite_rr_arbiter: RTL and testbench

- Shares one AXI4-Lite master port (32-bit address, 128-bit data, 16-bit strobe) among NUM_REQ simple request ports using round-robin arbitration.
- Sequences each granted request into a complete AXI4-Lite write (AW+W, then B) or read (AR, then R) transaction.
- Returns the response to the owning requester only.
- Sits between local agents (DMA/config engines) and the AXI4-Lite master interface; exactly one transaction is outstanding at a time.

---
 rtl/axi4lite_arb_pkg.sv | 22 ++
 rtl/rr_arbiter.sv | 39 +++
 rtl/axi4lite_rr_arbiter.sv | 243 ++++++++++++++++++++++++
 tb/tb_axi4lite_rr_arbiter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4lite_arb_pkg.sv
// Shared types and constants for the AXI4-Lite round-robin arbiter.
// Transaction state encoding and AXI response codes.
package axi4lite_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WADDR,
        WRESP,
        RADDR,
        RDATA
    } arb_state_e;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] EXOKAY = 2'b01;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    localparam int unsigned DEF_NUM_REQ = 4;
    localparam int unsigned DEF_ADDR_W  = 32;
    localparam int unsigned DEF_DATA_W  = 128;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping.
// Produces a one-hot grant, its index and an any-grant flag.
module rr_arbiter #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]          req,
    input  logic [$clog2(N)-1:0]  ptr,
    output logic [N-1:0]          gnt,
    output logic [$clog2(N)-1:0]  gnt_idx,
    output logic                  gnt_any
);

    localparam int unsigned IDX_W = $clog2(N);

    logic [IDX_W:0]   pos;
    logic [IDX_W-1:0] idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        pos     = '0;
        idx     = '0;
        for (int unsigned k = 0; k < N; k++) begin
            // One extra bit so ptr+k never overflows before the wrap subtraction.
            pos = {1'b0, ptr} + (IDX_W + 1)'(k);
            if (pos >= (IDX_W + 1)'(N)) begin
                pos = pos - (IDX_W + 1)'(N);
            end
            idx = pos[IDX_W-1:0];
            if (!gnt_any && req[idx]) begin
                gnt_any  = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/axi4lite_rr_arbiter.sv
// Shares one AXI4-Lite master port among NUM_REQ requesters, round-robin,
// one outstanding transaction at a time; responses go back to the owner only.
module axi4lite_rr_arbiter
    import axi4lite_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEF_NUM_REQ,
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned DATA_W  = DEF_DATA_W
) (
    input  logic                           clk,
    input  logic                           rst_n,

    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ-1:0]             req_write,
    input  logic [NUM_REQ*ADDR_W-1:0]      req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]      req_wdata,
    input  logic [NUM_REQ*DATA_W/8-1:0]    req_wstrb,
    output logic [NUM_REQ-1:0]             rsp_valid,
    output logic [DATA_W-1:0]              rsp_rdata,
    output logic [1:0]                     rsp_resp,
    output logic                           busy,
    output logic [$clog2(NUM_REQ)-1:0]     grant_id,

    output logic [ADDR_W-1:0]              awaddr,
    output logic                           awvalid,
    input  logic                           awready,
    output logic [DATA_W-1:0]              wdata,
    output logic [DATA_W/8-1:0]            wstrb,
    output logic                           wvalid,
    input  logic                           wready,
    input  logic [1:0]                     bresp,
    input  logic                           bvalid,
    output logic                           bready,
    output logic [ADDR_W-1:0]              araddr,
    output logic                           arvalid,
    input  logic                           arready,
    input  logic [DATA_W-1:0]              rdata,
    input  logic [1:0]                     rresp,
    input  logic                           rvalid,
    output logic                           rready
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned ID_W   = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] arb_gnt;
    logic [ID_W-1:0]    arb_idx;
    logic               arb_any;

    logic               sel_write;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_wdata;
    logic [STRB_W-1:0]  sel_wstrb;

    arb_state_e         state_q, state_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [ID_W-1:0]    grant_id_q, grant_id_d;
    logic [NUM_REQ-1:0] owner_q, owner_d;
    logic               busy_q, busy_d;
    logic [NUM_REQ-1:0] req_ready_q, req_ready_d;
    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]  rsp_rdata_q, rsp_rdata_d;
    logic [1:0]         rsp_resp_q, rsp_resp_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [STRB_W-1:0]  wstrb_q, wstrb_d;
    logic               awvalid_q, awvalid_d;
    logic               wvalid_q, wvalid_d;
    logic               aw_done_q, aw_done_d;
    logic               w_done_q, w_done_d;
    logic               bready_q, bready_d;
    logic               arvalid_q, arvalid_d;
    logic               rready_q, rready_d;

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_rr_arbiter (
        .req     (req_valid),
        .ptr     (ptr_q),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx),
        .gnt_any (arb_any)
    );

    always_comb begin
        sel_write = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_wstrb = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (arb_idx == ID_W'(i)) begin
                sel_write = req_write[i];
                sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = req_wdata[i*DATA_W +: DATA_W];
                sel_wstrb = req_wstrb[i*STRB_W +: STRB_W];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        grant_id_d  = grant_id_q;
        owner_d     = owner_q;
        busy_d      = busy_q;
        req_ready_d = '0;
        rsp_valid_d = '0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;

        unique case (state_q)
            IDLE: begin
                if (arb_any) begin
                    req_ready_d = arb_gnt;
                    owner_d     = arb_gnt;
                    grant_id_d  = arb_idx;
                    busy_d      = 1'b1;
                    addr_d      = sel_addr;
                    wdata_d     = sel_wdata;
                    wstrb_d     = sel_wstrb;
                    state_d     = sel_write ? WADDR : RADDR;
                end
            end
            WADDR: begin
                // Valids rise on the first WADDR cycle and each falls on its own handshake.
                aw_done_d = aw_done_q | (awvalid_q & awready);
                w_done_d  = w_done_q | (wvalid_q & wready);
                awvalid_d = !aw_done_d;
                wvalid_d  = !w_done_d;
                if (aw_done_d && w_done_d) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    bready_d  = 1'b1;
                    state_d   = WRESP;
                end
            end
            WRESP: begin
                if (bvalid && bready_q) begin
                    bready_d    = 1'b0;
                    rsp_valid_d = owner_q;
                    rsp_rdata_d = '0;
                    rsp_resp_d  = bresp;
                    busy_d      = 1'b0;
                    ptr_d       = (grant_id_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_id_q + ID_W'(1);
                    state_d     = IDLE;
                end
            end
            RADDR: begin
                if (arvalid_q && arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RDATA;
                end else begin
                    arvalid_d = 1'b1;
                end
            end
            RDATA: begin
                if (rvalid && rready_q) begin
                    rready_d    = 1'b0;
                    rsp_valid_d = owner_q;
                    rsp_rdata_d = rdata;
                    rsp_resp_d  = rresp;
                    busy_d      = 1'b0;
                    ptr_d       = (grant_id_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_id_q + ID_W'(1);
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            grant_id_q  <= '0;
            owner_q     <= '0;
            busy_q      <= 1'b0;
            req_ready_q <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= OKAY;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            grant_id_q  <= grant_id_d;
            owner_q     <= owner_d;
            busy_q      <= busy_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_resp  = rsp_resp_q;
    assign busy      = busy_q;
    assign grant_id  = grant_id_q;
    assign awaddr    = addr_q;
    assign araddr    = addr_q;
    assign awvalid   = awvalid_q;
    assign wdata     = wdata_q;
    assign wstrb     = wstrb_q;
    assign wvalid    = wvalid_q;
    assign bready    = bready_q;
    assign arvalid   = arvalid_q;
    assign rready    = rready_q;

endmodule

// File: tb/tb_axi4lite_rr_arbiter.sv
// Directed bench for axi4lite_rr_arbiter: table of transactions driven by a
// scripted AXI slave, plus fairness and reset-abort sequences.
module tb_axi4lite_rr_arbiter;
    import axi4lite_arb_pkg::*;

    localparam int unsigned N  = 4;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 128;
    localparam int unsigned SW = DW / 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    req_write = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N*DW-1:0] req_wdata = '0;
    logic [N*SW-1:0] req_wstrb = '0;
    logic [N-1:0]    rsp_valid;
    logic [DW-1:0]   rsp_rdata;
    logic [1:0]      rsp_resp;
    logic            busy;
    logic [1:0]      grant_id;
    logic [AW-1:0]   awaddr, araddr;
    logic            awvalid, wvalid, bready, arvalid, rready;
    logic [DW-1:0]   wdata;
    logic [SW-1:0]   wstrb;
    logic            awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0;
    logic [1:0]      bresp = 2'b00, rresp = 2'b00;
    logic [DW-1:0]   rdata = '0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    axi4lite_rr_arbiter #(
        .NUM_REQ (N),
        .ADDR_W  (AW),
        .DATA_W  (DW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wstrb (req_wstrb),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_resp  (rsp_resp),
        .busy      (busy),
        .grant_id  (grant_id),
        .awaddr    (awaddr),
        .awvalid   (awvalid),
        .awready   (awready),
        .wdata     (wdata),
        .wstrb     (wstrb),
        .wvalid    (wvalid),
        .wready    (wready),
        .bresp     (bresp),
        .bvalid    (bvalid),
        .bready    (bready),
        .araddr    (araddr),
        .arvalid   (arvalid),
        .arready   (arready),
        .rdata     (rdata),
        .rresp     (rresp),
        .rvalid    (rvalid),
        .rready    (rready)
    );

    // d0/d1/d2: write = aw delay, w delay, b delay; read = ar delay, unused, r delay.
    typedef struct {
        logic          write;
        logic [N-1:0]  mask;
        int unsigned   exp_g;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [SW-1:0] strb;
        int unsigned   d0;
        int unsigned   d1;
        int unsigned   d2;
        logic [1:0]    resp;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Granted requester carries the vector payload, the others carry its inverse.
    task automatic set_payload(input vec_t v);
        for (int i = 0; i < int'(N); i++) begin
            req_write[i]            = (i == int'(v.exp_g)) ? v.write : ~v.write;
            req_addr[i*AW +: AW]    = (i == int'(v.exp_g)) ? v.addr : ~v.addr;
            req_wdata[i*DW +: DW]   = (i == int'(v.exp_g)) ? v.data : ~v.data;
            req_wstrb[i*SW +: SW]   = (i == int'(v.exp_g)) ? v.strb : ~v.strb;
        end
    endtask

    task automatic accept(input logic [N-1:0] mask, input int unsigned g, input logic keep);
        int unsigned cyc = 0;
        req_valid = mask;
        @(negedge clk);
        chk("rsp_valid_pulse_end", rsp_valid, '0);
        while (req_ready == '0 && cyc < 8) begin
            @(negedge clk);
            cyc++;
        end
        chk("req_ready", req_ready, (1 << g));
        chk("grant_id", grant_id, g);
        chk("busy_accept", busy, 1);
        chk("no_axi_valid_at_accept", {awvalid, wvalid, arvalid}, 0);
        if (!keep) req_valid[g] = 1'b0;
    endtask

    task automatic write_phase(input vec_t v);
        int unsigned last;
        logic aw_done, w_done;
        last = (v.d0 > v.d1) ? v.d0 : v.d1;
        aw_done = 1'b0;
        w_done = 1'b0;
        @(negedge clk);
        chk("req_ready_pulse_end", req_ready, '0);
        for (int unsigned c = 0; c <= last; c++) begin
            chk("awvalid", awvalid, !aw_done);
            chk("wvalid", wvalid, !w_done);
            chk("bready_early", bready, 0);
            if (!aw_done) chk("awaddr", awaddr, v.addr);
            if (!w_done) begin
                chk("wdata", wdata, v.data);
                chk("wstrb", wstrb, v.strb);
            end
            awready = (c == v.d0);
            wready  = (c == v.d1);
            @(negedge clk);
            if (c == v.d0) aw_done = 1'b1;
            if (c == v.d1) w_done = 1'b1;
        end
        awready = 1'b0;
        wready  = 1'b0;
        chk("aw_w_dropped", {awvalid, wvalid}, 0);
        chk("bready", bready, 1);
        repeat (v.d2) begin
            @(negedge clk);
            chk("bready_hold", bready, 1);
            chk("rsp_valid_wait", rsp_valid, '0);
        end
        bvalid = 1'b1;
        bresp  = v.resp;
        @(negedge clk);
        bvalid = 1'b0;
        bresp  = 2'b00;
        chk("rsp_valid_w", rsp_valid, (1 << v.exp_g));
        chk("rsp_resp_w", rsp_resp, v.resp);
        chk("rsp_rdata_w", rsp_rdata, '0);
        chk("busy_done_w", busy, 0);
        chk("bready_done", bready, 0);
    endtask

    task automatic read_phase(input vec_t v);
        @(negedge clk);
        chk("req_ready_pulse_end", req_ready, '0);
        for (int unsigned c = 0; c <= v.d0; c++) begin
            chk("arvalid", arvalid, 1);
            chk("rready_early", rready, 0);
            chk("araddr", araddr, v.addr);
            arready = (c == v.d0);
            @(negedge clk);
        end
        arready = 1'b0;
        chk("arvalid_dropped", arvalid, 0);
        chk("rready", rready, 1);
        repeat (v.d2) begin
            @(negedge clk);
            chk("rready_hold", rready, 1);
            chk("rsp_valid_wait", rsp_valid, '0);
        end
        rvalid = 1'b1;
        rdata  = v.data;
        rresp  = v.resp;
        @(negedge clk);
        rvalid = 1'b0;
        rdata  = '0;
        rresp  = 2'b00;
        chk("rsp_valid_r", rsp_valid, (1 << v.exp_g));
        chk("rsp_rdata_r", rsp_rdata, v.data);
        chk("rsp_resp_r", rsp_resp, v.resp);
        chk("busy_done_r", busy, 0);
        chk("rready_done", rready, 0);
    endtask

    task automatic do_txn(input vec_t v, input logic keep);
        set_payload(v);
        accept(v.mask, v.exp_g, keep);
        if (v.write) write_phase(v);
        else read_phase(v);
    endtask

    initial begin
        vec_t v;
        // Pointer chain: 0 ->3 ->2 ->1 ->2 ->3 ->0 ->1 ->3 ->0 ->2 ->3 ->0
        tbl[0]  = '{1'b1, 4'b0100, 2, 32'h0000_1000, 128'h0123_4567_89AB_CDEF_0011_2233_DEAD_BEEF, 16'hFFFF, 0, 0, 0, OKAY};
        tbl[1]  = '{1'b1, 4'b0010, 1, 32'h0000_2004, 128'hCAFE_F00D_0000_0000_1111_2222_3333_4444, 16'h00F0, 3, 0, 2, OKAY};
        tbl[2]  = '{1'b0, 4'b0001, 0, 32'h0000_0020, 128'h1234_5678, 16'h0000, 0, 0, 5, SLVERR};
        tbl[3]  = '{1'b1, 4'b1111, 1, 32'h0000_3000, 128'h5555_AAAA_5555_AAAA_5555_AAAA_5555_AAAA, 16'h000F, 1, 1, 1, DECERR};
        tbl[4]  = '{1'b0, 4'b1101, 2, 32'h0000_4000, 128'hA5A5_A5A5_0000_0000_FFFF_FFFF_0F0F_0F0F, 16'h0000, 2, 0, 0, EXOKAY};
        tbl[5]  = '{1'b1, 4'b1001, 3, 32'h0000_5000, 128'h0000_0000_0000_0000_0000_0000_0BAD_CAFE, 16'h8001, 0, 2, 0, OKAY};
        tbl[6]  = '{1'b0, 4'b0001, 0, 32'h0000_6000, 128'h7777_6666_5555_4444_3333_2222_1111_0000, 16'h0000, 0, 0, 1, OKAY};
        tbl[7]  = '{1'b1, 4'b0100, 2, 32'h0000_7000, 128'h1, 16'h0001, 1, 1, 0, SLVERR};
        tbl[8]  = '{1'b0, 4'b1010, 3, 32'h0000_8000, 128'h8888, 16'h0000, 1, 0, 2, OKAY};
        tbl[9]  = '{1'b1, 4'b0010, 1, 32'h0000_9000, 128'h9999, 16'h0F0F, 2, 2, 0, OKAY};
        tbl[10] = '{1'b0, 4'b0100, 2, 32'h0000_A000, 128'hAAAA, 16'h0000, 0, 0, 0, DECERR};
        tbl[11] = '{1'b1, 4'b1000, 3, 32'h0000_B000, 128'hBBBB, 16'hF000, 0, 1, 1, OKAY};

        repeat (2) @(negedge clk);
        chk("rst_req_ready", req_ready, '0);
        chk("rst_rsp_valid", rsp_valid, '0);
        chk("rst_busy_grant", {busy, grant_id}, 0);
        chk("rst_axi_valids", {awvalid, wvalid, bready, arvalid, rready}, 0);
        chk("rst_rsp_data", {rsp_rdata, rsp_resp}, 0);
        rst_n = 1'b1;

        foreach (tbl[i]) do_txn(tbl[i], 1'b0);

        // Fairness: all four held high, pointer starts at 0.
        for (int k = 0; k < 8; k++) begin
            v = '{1'b0, 4'b1111, k % 4, 32'h0000_0100 * (k + 1), 128'(k + 1), 16'h0000, 0, 0, 0, OKAY};
            do_txn(v, 1'b1);
        end
        req_valid = '0;

        // Move pointer to 2, then abort a read from requester 2 by reset.
        v = '{1'b1, 4'b0010, 1, 32'h0000_C000, 128'hC, 16'h0003, 0, 0, 0, OKAY};
        do_txn(v, 1'b0);
        v = '{1'b0, 4'b0100, 2, 32'h0000_D000, 128'hD, 16'h0000, 0, 0, 0, OKAY};
        set_payload(v);
        accept(4'b0100, 2, 1'b0);
        @(negedge clk);
        chk("abort_arvalid", arvalid, 1);
        arready = 1'b1;
        @(negedge clk);
        arready = 1'b0;
        chk("abort_rready", rready, 1);
        req_valid = 4'b1010;
        @(negedge clk);
        chk("wait_while_busy", req_ready, '0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_valids", {arvalid, rready, awvalid, wvalid, bready}, 0);
        chk("abort_busy", busy, 0);
        chk("abort_rsp_valid", rsp_valid, '0);
        chk("abort_grant_id", grant_id, 0);
        @(negedge clk);
        rst_n = 1'b1;
        v = '{1'b0, 4'b1010, 1, 32'h0000_E000, 128'hE0E0, 16'h0000, 0, 0, 1, OKAY};
        do_txn(v, 1'b0);
        v = '{1'b1, 4'b1000, 3, 32'h0000_F000, 128'hF0F0, 16'h00FF, 1, 0, 0, OKAY};
        do_txn(v, 1'b0);
        @(negedge clk);
        chk("final_idle", {busy, rsp_valid}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
